// File: rtl/led_chain_ctrl_pkg.sv
// rtl/led_chain_ctrl_pkg.sv - shared state encoding and chain constants for the LED chain scheduler
package led_chain_ctrl_pkg;

  // Chain geometry shared by the framebuffer and the chain controller
  localparam int c_def_ledboards       = 30;
  localparam int c_def_words_per_board = 12;
  localparam int c_def_bits            = 12;
  localparam int c_def_lat_cycles      = 2;
  localparam int c_def_addr_w          = 9;

  typedef enum logic [2:0] {
    st_idle     = 3'd0,
    st_fetch    = 3'd1,
    st_load     = 3'd2,
    st_shift_lo = 3'd3,
    st_shift_hi = 3'd4,
    st_latch    = 3'd5,
    st_done     = 3'd6
  } state_t;

endpackage

// File: rtl/led_chain_ctrl_piso_shift.sv
// rtl/led_chain_ctrl_piso_shift.sv - parallel-load shift-left register with remaining-bit counter
module led_chain_ctrl_piso_shift #(
  parameter int c_bits = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              load,
  input  logic              shift,
  input  logic [c_bits-1:0] data,
  output logic              msb,
  output logic              last
);

  localparam int c_cnt_w = (c_bits > 1) ? $clog2(c_bits) : 1;

  logic [c_bits-1:0]  sr;
  logic [c_cnt_w-1:0] cnt;

  // Load a word with cnt = bits still to go after the current msb; shift moves the next bit up
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data;
      cnt <= c_cnt_w'(c_bits - 1);
    end else if (shift) begin
      sr <= {sr[c_bits-2:0], 1'b0};
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign msb  = sr[c_bits-1];
  assign last = (cnt == '0);

endmodule

// File: rtl/led_chain_ctrl.sv
// rtl/led_chain_ctrl.sv - frame scheduler serialising the framebuffer onto the LED driver chain
module led_chain_ctrl
  import led_chain_ctrl_pkg::*;
#(
  parameter int c_ledboards       = c_def_ledboards,
  parameter int c_words_per_board = c_def_words_per_board,
  parameter int c_bits            = c_def_bits,
  parameter int c_lat_cycles      = c_def_lat_cycles,
  parameter int c_addr_w          = c_def_addr_w
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic [c_addr_w-1:0] o_addr,
  input  logic [c_bits-1:0]   i_data,
  output logic                o_clk,
  output logic                o_dai,
  output logic                o_lat,
  output logic                o_busy,
  output logic                o_done
);

  localparam int                  c_n         = c_ledboards * c_words_per_board;
  localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(c_n - 1);
  localparam int                  c_lat_w     = (c_lat_cycles > 1) ? $clog2(c_lat_cycles) : 1;

  state_t              state;
  logic [c_addr_w-1:0] word_cnt;
  logic [c_lat_w-1:0]  lat_cnt;
  logic                bit_last;
  logic                sr_load;
  logic                sr_shift;
  logic                sr_msb;
  logic                sr_last;

  // The shift register advances on the low-to-high step so the next bit is ready when o_clk falls
  always_comb begin
    sr_load  = (state == st_load);
    sr_shift = (state == st_shift_lo) && !sr_last;
  end

  led_chain_ctrl_piso_shift #(
    .c_bits(c_bits)
  ) u_piso (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .load (sr_load),
    .shift(sr_shift),
    .data (i_data),
    .msb  (sr_msb),
    .last (sr_last)
  );

  // Frame sequencer; every output is assigned on the edge entering the state it belongs to
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= st_idle;
      o_addr   <= '0;
      o_clk    <= 1'b0;
      o_dai    <= 1'b0;
      o_lat    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      word_cnt <= '0;
      lat_cnt  <= '0;
      bit_last <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (i_start) begin
            o_busy   <= 1'b1;
            o_addr   <= c_last_addr;
            word_cnt <= c_last_addr;
            state    <= st_fetch;
          end
        end
        st_fetch: state <= st_load;
        st_load: begin
          o_dai <= i_data[c_bits-1];
          state <= st_shift_lo;
        end
        st_shift_lo: begin
          o_clk    <= 1'b1;
          bit_last <= sr_last;
          state    <= st_shift_hi;
        end
        st_shift_hi: begin
          o_clk <= 1'b0;
          if (!bit_last) begin
            o_dai <= sr_msb;
            state <= st_shift_lo;
          end else if (word_cnt != '0) begin
            word_cnt <= word_cnt - 1'b1;
            o_addr   <= o_addr - 1'b1;
            state    <= st_fetch;
          end else begin
            o_lat   <= 1'b1;
            lat_cnt <= c_lat_w'(c_lat_cycles - 1);
            state   <= st_latch;
          end
        end
        st_latch: begin
          if (lat_cnt == '0) begin
            o_lat  <= 1'b0;
            o_done <= 1'b1;
            state  <= st_done;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        st_done: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_chain_ctrl.sv
// tb/tb_led_chain_ctrl.sv - self-checking bench for led_chain_ctrl with a small and a default chain
module tb_led_chain_ctrl;

  localparam int S_BITS = 4;
  localparam int S_N    = 2;
  localparam int S_AW   = 1;
  localparam int S_LAT  = 2;
  localparam int S_FRAME = 1 + S_N * (2 + 2 * S_BITS) + S_LAT + 1;
  localparam int D_BITS = 12;
  localparam int D_N    = 360;
  localparam int D_AW   = 9;
  localparam int D_FRAME = 1 + D_N * (2 + 2 * D_BITS) + 2 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              s_start = 1'b0;
  logic [S_AW-1:0]   s_addr;
  logic [S_BITS-1:0] s_data;
  logic              s_clk, s_dai, s_lat, s_busy, s_done;
  logic              d_start = 1'b0;
  logic [D_AW-1:0]   d_addr;
  logic [D_BITS-1:0] d_data;
  logic              d_clk, d_dai, d_lat, d_busy, d_done;

  led_chain_ctrl #(.c_ledboards(1), .c_words_per_board(S_N), .c_bits(S_BITS),
                   .c_lat_cycles(S_LAT), .c_addr_w(S_AW)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .o_addr(s_addr), .i_data(s_data),
    .o_clk(s_clk), .o_dai(s_dai), .o_lat(s_lat), .o_busy(s_busy), .o_done(s_done));

  led_chain_ctrl dut_d (
    .i_clk(clk), .i_rst(rst), .i_start(d_start), .o_addr(d_addr), .i_data(d_data),
    .o_clk(d_clk), .o_dai(d_dai), .o_lat(d_lat), .o_busy(d_busy), .o_done(d_done));

  // Framebuffer models: one-cycle registered read
  logic [S_BITS-1:0] mem_s [S_N];
  logic [D_BITS-1:0] mem_d [D_N];
  always @(posedge clk) s_data <= mem_s[s_addr];
  always @(posedge clk) d_data <= mem_d[d_addr];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int s_exp_bits[$], s_obs_bits[$], s_exp_addr[$], s_obs_addr[$];
  int s_start_q[$], s_done_q[$], s_lat_q[$];
  int d_exp_addr[$], d_obs_addr[$], d_start_q[$], d_done_q[$];
  int s_viol = 0, d_viol = 0, d_rises = 0, d_zero_rises = 0;
  logic ps_clk = 0, ps_dai = 0, ps_busy = 0, pd_clk = 0, pd_dai = 0, pd_busy = 0;
  logic [S_AW-1:0] ps_addr = '0;
  logic [D_AW-1:0] pd_addr = '0;

  // Monitor: record chain events and protocol violations once per cycle
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (!rst) begin
      if (s_start && !s_busy) s_start_q.push_back(ncyc);
      if (s_clk && !ps_clk) s_obs_bits.push_back(int'(s_dai));
      if (s_busy && (!ps_busy || s_addr != ps_addr)) s_obs_addr.push_back(int'(s_addr));
      if (s_lat) s_lat_q.push_back(ncyc);
      if (s_done) s_done_q.push_back(ncyc);
      if (s_lat && s_clk) s_viol++;
      if (s_clk && s_dai != ps_dai) s_viol++;
      if (d_start && !d_busy) d_start_q.push_back(ncyc);
      if (d_clk && !pd_clk) begin
        d_rises++;
        if (!d_dai) d_zero_rises++;
      end
      if (d_busy && (!pd_busy || d_addr != pd_addr)) d_obs_addr.push_back(int'(d_addr));
      if (d_done) d_done_q.push_back(ncyc);
      if (d_lat && d_clk) d_viol++;
      if (d_clk && d_dai != pd_dai) d_viol++;
    end
    ps_clk = s_clk; ps_dai = s_dai; ps_busy = s_busy; ps_addr = s_addr;
    pd_clk = d_clk; pd_dai = d_dai; pd_busy = d_busy; pd_addr = d_addr;
  end

  task automatic clear_small();
    s_exp_bits.delete(); s_obs_bits.delete(); s_exp_addr.delete(); s_obs_addr.delete();
    s_start_q.delete(); s_done_q.delete(); s_lat_q.delete();
  endtask

  task automatic push_frame_small();
    for (int w = S_N - 1; w >= 0; w--) begin
      logic [S_BITS-1:0] word;
      word = mem_s[w];
      s_exp_addr.push_back(w);
      for (int b = S_BITS - 1; b >= 0; b--) s_exp_bits.push_back(int'(word[b]));
    end
  endtask

  task automatic pulse_start_small();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({s_addr, s_clk, s_dai, s_lat, s_busy, s_done} !== '0 ||
          {d_addr, d_clk, d_dai, d_lat, d_busy, d_done} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got small=%b default=%b want all zero", i,
                 {s_addr, s_clk, s_dai, s_lat, s_busy, s_done},
                 {d_addr, d_clk, d_dai, d_lat, d_busy, d_done});
      end
    end
  endtask

  task automatic test_single_frame();
    int budget;
    clear_small();
    mem_s[1] = 4'hA;
    mem_s[0] = 4'h3;
    push_frame_small();
    pulse_start_small();
    budget = 0;
    while (s_done_q.size() < 1 && budget < 100) begin
      @(negedge clk); #1; budget++;
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (s_done_q.size() != 1 || s_start_q.size() != 1) begin
      errors++;
      $display("FAIL frame_done_count got done=%0d start=%0d want 1 and 1", s_done_q.size(), s_start_q.size());
    end else begin
      checks++;
      if (s_done_q[0] - s_start_q[0] + 1 != S_FRAME) begin
        errors++;
        $display("FAIL frame_latency got %0d want %0d", s_done_q[0] - s_start_q[0] + 1, S_FRAME);
      end
      checks++;
      if (s_lat_q.size() != S_LAT || s_lat_q[0] != s_done_q[0] - 2 || s_lat_q[S_LAT-1] != s_done_q[0] - 1) begin
        errors++;
        $display("FAIL frame_latch got %0d lat cycles want %0d just before done", s_lat_q.size(), S_LAT);
      end
    end
    checks++;
    if (s_obs_addr.size() != s_exp_addr.size() || s_obs_bits.size() != s_exp_bits.size()) begin
      errors++;
      $display("FAIL frame_counts got addr=%0d bits=%0d want addr=%0d bits=%0d",
               s_obs_addr.size(), s_obs_bits.size(), s_exp_addr.size(), s_exp_bits.size());
    end
    while (s_exp_addr.size() > 0 && s_obs_addr.size() > 0) begin
      int e, o;
      e = s_exp_addr.pop_front(); o = s_obs_addr.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL frame_addr got %0d want %0d", o, e); end
    end
    while (s_exp_bits.size() > 0 && s_obs_bits.size() > 0) begin
      int e, o;
      e = s_exp_bits.pop_front(); o = s_obs_bits.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL frame_bit got %0d want %0d", o, e); end
    end
    checks++;
    if (s_viol != 0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_protocol got viol=%0d busy=%b want 0 and 0", s_viol, s_busy);
    end
  endtask

  task automatic test_back_to_back();
    int budget;
    clear_small();
    mem_s[1] = 4'($urandom_range(0, 15));
    mem_s[0] = 4'($urandom_range(0, 15));
    for (int f = 0; f < 3; f++) push_frame_small();
    @(posedge clk); #1 s_start = 1'b1;
    budget = 0;
    while (s_done_q.size() < 3 && budget < 200) begin
      @(negedge clk); #1; budget++;
    end
    @(posedge clk); #1 s_start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (s_done_q.size() != 3 || s_start_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_frames got done=%0d accepted=%0d want 3 and 3", s_done_q.size(), s_start_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (s_done_q[k] - s_start_q[k] + 1 != S_FRAME) begin
          errors++;
          $display("FAIL b2b_latency frame %0d got %0d want %0d", k, s_done_q[k] - s_start_q[k] + 1, S_FRAME);
        end
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (s_start_q[k+1] != s_done_q[k] + 1) begin
          errors++;
          $display("FAIL b2b_gap frame %0d got restart at %0d want %0d", k, s_start_q[k+1], s_done_q[k] + 1);
        end
      end
    end
    checks++;
    if (s_obs_bits.size() != s_exp_bits.size()) begin
      errors++;
      $display("FAIL b2b_bit_count got %0d want %0d", s_obs_bits.size(), s_exp_bits.size());
    end
    while (s_exp_bits.size() > 0 && s_obs_bits.size() > 0) begin
      int e, o;
      e = s_exp_bits.pop_front(); o = s_obs_bits.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_bit got %0d want %0d", o, e); end
    end
    while (s_exp_addr.size() > 0 && s_obs_addr.size() > 0) begin
      int e, o;
      e = s_exp_addr.pop_front(); o = s_obs_addr.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_addr got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int budget;
    clear_small();
    mem_s[1] = 4'h5;
    mem_s[0] = 4'hC;
    pulse_start_small();
    budget = 0;
    while (!(s_clk && s_obs_bits.size() == 3) && budget < 60) begin
      @(negedge clk); #1; budget++;
    end
    checks++;
    if (budget >= 60) begin errors++; $display("FAIL midrst_reach_third_hi got timeout want third shift"); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({s_addr, s_clk, s_dai, s_lat, s_busy, s_done} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got %b want all zero", {s_addr, s_clk, s_dai, s_lat, s_busy, s_done});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (s_lat_q.size() != 0 || s_done_q.size() != 0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_latch got lat=%0d done=%0d busy=%b want 0 0 0", s_lat_q.size(), s_done_q.size(), s_busy);
    end
    clear_small();
    push_frame_small();
    pulse_start_small();
    budget = 0;
    while (s_done_q.size() < 1 && budget < 100) begin
      @(negedge clk); #1; budget++;
    end
    checks++;
    if (s_obs_bits.size() != s_exp_bits.size() || s_obs_addr.size() != s_exp_addr.size()) begin
      errors++;
      $display("FAIL midrst_restart_counts got bits=%0d addr=%0d want %0d %0d",
               s_obs_bits.size(), s_obs_addr.size(), s_exp_bits.size(), s_exp_addr.size());
    end
    while (s_exp_addr.size() > 0 && s_obs_addr.size() > 0) begin
      int e, o;
      e = s_exp_addr.pop_front(); o = s_obs_addr.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL midrst_addr got %0d want %0d", o, e); end
    end
    while (s_exp_bits.size() > 0 && s_obs_bits.size() > 0) begin
      int e, o;
      e = s_exp_bits.pop_front(); o = s_obs_bits.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL midrst_bit got %0d want %0d", o, e); end
    end
    checks++;
    if (s_viol != 0) begin errors++; $display("FAIL midrst_protocol got %0d violations want 0", s_viol); end
  endtask

  task automatic test_defaults();
    int budget;
    for (int i = 0; i < D_N; i++) mem_d[i] = 12'hFFF;
    d_exp_addr.delete(); d_obs_addr.delete(); d_start_q.delete(); d_done_q.delete();
    d_rises = 0; d_zero_rises = 0;
    for (int w = D_N - 1; w >= 0; w--) d_exp_addr.push_back(w);
    @(posedge clk); #1 d_start = 1'b1;
    @(posedge clk); #1 d_start = 1'b0;
    budget = 0;
    while (d_done_q.size() < 1 && budget < 12000) begin
      @(negedge clk); #1; budget++;
    end
    checks++;
    if (d_done_q.size() != 1 || d_start_q.size() != 1) begin
      errors++;
      $display("FAIL default_done got done=%0d start=%0d want 1 and 1", d_done_q.size(), d_start_q.size());
    end else begin
      checks++;
      if (d_done_q[0] - d_start_q[0] + 1 != D_FRAME) begin
        errors++;
        $display("FAIL default_latency got %0d want %0d", d_done_q[0] - d_start_q[0] + 1, D_FRAME);
      end
    end
    checks++;
    if (d_rises != D_N * D_BITS || d_zero_rises != 0) begin
      errors++;
      $display("FAIL default_bits got rises=%0d zeros=%0d want %0d and 0", d_rises, d_zero_rises, D_N * D_BITS);
    end
    checks++;
    if (d_obs_addr.size() != D_N) begin
      errors++;
      $display("FAIL default_addr_count got %0d want %0d", d_obs_addr.size(), D_N);
    end
    while (d_exp_addr.size() > 0 && d_obs_addr.size() > 0) begin
      int e, o;
      e = d_exp_addr.pop_front(); o = d_obs_addr.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL default_addr got %0d want %0d", o, e); end
    end
    checks++;
    if (d_viol != 0) begin errors++; $display("FAIL default_protocol got %0d violations want 0", d_viol); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_defaults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
